// File: rtl/fp_pkg.sv
// Shared FP definitions for the multiplier issue/collect stage: flag positions,
// rounding-mode encodings, canonical quiet NaNs and the issue FSM state codes.
package fp_pkg;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // A multiply can never divide by zero, so DZ is always packed as 0.
  function automatic logic [4:0] pack_fflags(input logic nv, input logic of,
                                             input logic uf, input logic nx);
    logic [4:0] f;
    f        = '0;
    f[FF_NV] = nv;
    f[FF_DZ] = 1'b0;
    f[FF_OF] = of;
    f[FF_UF] = uf;
    f[FF_NX] = nx;
    return f;
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous result FIFO between the multiplier and writeback.
// Storage resets to zero so the head fields read 0 while empty after reset.
module fp_wb_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fp_mul_issue_collector.sv
// Issue/collect wrapper around the FP multiplier: one op in flight, results queued
// for writeback with sticky fflags. Define FP_MUL_WATCHDOG_EN for the WAIT timeout.
module fp_mul_issue_collector
  import fp_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       req_rm,
  input  logic [FLEN-1:0]  req_a,
  input  logic [FLEN-1:0]  req_b,
  output logic             mul_start,
  output logic [2:0]       mul_rm,
  output logic [FLEN-1:0]  mul_a,
  output logic [FLEN-1:0]  mul_b,
  input  logic             mul_busy,
  input  logic             mul_done,
  input  logic [FLEN-1:0]  mul_result,
  input  logic             mul_nv,
  input  logic             mul_of,
  input  logic             mul_uf,
  input  logic             mul_nx,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [FLEN-1:0]  wb_data,
  output logic [4:0]       wb_fflags,
  output logic [4:0]       fflags_acc,
  input  logic             fflags_clr,
  output logic             err_timeout
);
  localparam int EW    = TAG_W + FLEN + 5;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [FLEN-1:0] QNAN = (FLEN == 64) ? FLEN'(QNAN64) : FLEN'(QNAN32);

  logic [1:0]       state;
  logic             ready_en;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] count;
  logic             full, empty, space, accept, push, retire, timeout;
  logic [EW-1:0]    push_data, head;

  assign space     = (count < CNT_W'(DEPTH)) && !full;
  // ready_en keeps req_ready low while reset is held and for the first clock after.
  assign req_ready = ready_en && (state == ST_IDLE) && space;
  assign accept    = req_valid && req_ready;
  assign mul_start = (state == ST_LAUNCH) && !mul_busy;
  assign push      = (state == ST_WAIT) && (mul_done || timeout);
  assign push_data = mul_done ? {tag_q, mul_result, pack_fflags(mul_nv, mul_of, mul_uf, mul_nx)}
                              : {tag_q, QNAN, pack_fflags(1'b1, 1'b0, 1'b0, 1'b0)};

  // Hold registers only reload on accept, so they stay stable through done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ready_en <= 1'b0;
      tag_q    <= '0;
      mul_rm   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: if (accept) begin
          tag_q  <= req_tag;
          mul_rm <= req_rm;
          mul_a  <= req_a;
          mul_b  <= req_b;
          state  <= ST_LAUNCH;
        end
        ST_LAUNCH: if (!mul_busy) state <= ST_WAIT;
        ST_WAIT:   if (push) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

`ifdef FP_MUL_WATCHDOG_EN
  logic [3:0] wd_cnt;
  logic       err_q;

  // Counter is 0 on the first WAIT cycle; fire on the 15th WAIT cycle with no done.
  assign timeout     = (state == ST_WAIT) && !mul_done && (wd_cnt == 4'd14);
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + 4'd1 : 4'd0;
      if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  fp_wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_data),
    .pop     (retire),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign wb_valid                     = !empty;
  assign {wb_tag, wb_data, wb_fflags} = head;
  assign retire                       = wb_valid && wb_ready;

  // A clear coinciding with a retire keeps that retire's flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        fflags_acc <= '0;
    else if (retire)     fflags_acc <= fflags_clr ? wb_fflags : (fflags_acc | wb_fflags);
    else if (fflags_clr) fflags_acc <= '0;
  end

endmodule

// File: tb/tb_fp_mul_issue_collector.sv
// Scoreboard bench for fp_mul_issue_collector with a behavioural multiplier stub.
module tb_fp_mul_issue_collector;
  import fp_pkg::*;

  localparam int FLEN = 32, DEPTH = 2, TAG_W = 5;
  localparam logic [31:0] ONE = 32'h3F80_0000, TWO = 32'h4000_0000, INF = 32'h7F80_0000;

  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid, req_ready, mul_start, mul_busy, mul_done;
  logic [TAG_W-1:0] req_tag, wb_tag;
  logic [2:0] req_rm, mul_rm;
  logic [FLEN-1:0] req_a, req_b, mul_a, mul_b, mul_result, wb_data;
  logic mul_nv, mul_of, mul_uf, mul_nx, wb_valid, wb_ready, fflags_clr, err_timeout;
  logic [4:0] wb_fflags, fflags_acc;

  fp_mul_issue_collector #(.FLEN(FLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .mul_start(mul_start), .mul_rm(mul_rm), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_done(mul_done), .mul_result(mul_result),
    .mul_nv(mul_nv), .mul_of(mul_of), .mul_uf(mul_uf), .mul_nx(mul_nx),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_data(wb_data),
    .wb_fflags(wb_fflags), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
    .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [4:0] tag; logic [31:0] data; logic [4:0] ff; } resp_t;
  resp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, busy_until = 0;
  int n_acc = 0, n_start = 0, n_ret = 0, last_acc_cyc = 0, last_start_cyc = 0;
  bit rand_busy = 0, suppress_done = 0;
  logic [4:0] acc_model = '0;
  logic [31:0] if_a = '0, if_b = '0;
  logic [2:0] if_rm = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: IEEE special cases from the test plan, otherwise an
  // arbitrary but deterministic function of the operands and rounding mode.
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] rm);
    logic [31:0] p;
    if ((a == INF && b == 0) || (a == 0 && b == INF)) return {QNAN32, 5'b10000};
    if (a == ONE) return {b, 5'b00000};
    p = (a * b) ^ {29'b0, rm};
    return {p, a[0] & b[0], 1'b0, a[1], b[1], a[2] ^ b[2]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier stub: operands sampled 1 cycle after start, rm 4 cycles after, done at 5.
  initial begin
    int phase;
    logic [31:0] sa, sb;
    logic [2:0] srm;
    logic [36:0] r;
    phase = 0; sa = '0; sb = '0; srm = '0;
    mul_busy = 0; mul_done = 0; mul_result = '0;
    {mul_nv, mul_of, mul_uf, mul_nx} = '0;
    forever begin
      @(posedge clk); #1;
      mul_busy = (cyc < busy_until) || (rand_busy && ($urandom_range(0, 2) == 0));
      #1;
      mul_done = 0;
      if (!reset_n) phase = 0;
      else if (phase == 0) begin
        if (mul_start) phase = 1;
      end else begin
        phase++;
        if (phase == 2) begin sa = mul_a; sb = mul_b; end
        if (phase == 5) srm = mul_rm;
        if (phase == 6 && !suppress_done) begin
          chk("held_operands", {mul_rm, mul_a, mul_b}, {if_rm, if_a, if_b});
          r = ref_mul(sa, sb, srm);
          mul_result = r[36:5];
          {mul_nv, mul_of, mul_uf, mul_nx} = {r[4], r[2], r[1], r[0]};
          mul_done = 1;
          phase = 0;
        end else if (phase >= 25) begin
          mul_result = 32'hDEAD_BEEF;
          {mul_nv, mul_of, mul_uf, mul_nx} = 4'b1111;
          mul_done = 1;
          phase = 0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    resp_t e;
    logic [36:0] r;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        exp_q.delete();
        acc_model = '0;
      end else begin
        chk("fflags_acc", fflags_acc, acc_model);
        if (mul_start) begin
          n_start++;
          last_start_cyc = cyc;
          chk("start_while_busy", mul_busy, 0);
        end
        if (wb_valid && wb_ready) begin
          n_ret++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_retire: got %0h expected none", {wb_tag, wb_data, wb_fflags});
            e = '0;
          end else begin
            e = exp_q.pop_front();
            chk("wb_entry", {wb_tag, wb_data, wb_fflags}, e);
          end
          acc_model = fflags_clr ? e.ff : (acc_model | e.ff);
        end else if (fflags_clr) acc_model = '0;
        if (req_valid && req_ready) begin
          n_acc++;
          last_acc_cyc = cyc;
          if_a = req_a; if_b = req_b; if_rm = req_rm;
          e.tag = req_tag;
          if (suppress_done) begin
            e.data = QNAN32;
            e.ff = 5'(1) << FF_NV;
          end else begin
            r = ref_mul(req_a, req_b, req_rm);
            {e.data, e.ff} = r;
          end
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] t, input logic [2:0] rm,
                       input logic [31:0] a, input logic [31:0] b);
    int n;
    req_valid = 1; req_tag = t; req_rm = rm; req_a = a; req_b = b;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    if (n >= 200) chk("issue_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid = 0; req_a = $urandom; req_b = $urandom;
  endtask

  task automatic wait_wb();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_valid && n < 60);
    if (n >= 60) chk("wb_valid_timeout", 1, 0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wb_valid) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) chk("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [2:0] rand_rm();
    case ($urandom_range(0, 4))
      0: return RM_RNE;
      1: return RM_RTZ;
      2: return RM_RDN;
      3: return RM_RUP;
      default: return RM_RMM;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base_acc, base_ret, base_start, n;
    bit rand_done;
    req_valid = 0; req_tag = '0; req_rm = '0; req_a = '0; req_b = '0;
    wb_ready = 0; fflags_clr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {req_ready, mul_start, mul_rm, mul_a, mul_b, wb_valid, wb_tag,
                          wb_data, wb_fflags, fflags_acc, err_timeout}, 0);
    @(posedge clk); #1 reset_n = 1;
    @(posedge clk); #1;

    // 1.0 * 2.0 with latency checks.
    wb_ready = 1;
    issue(7, RM_RNE, ONE, TWO);
    wait_wb();
    chk("latency_wb_valid", cyc - last_acc_cyc, 7);
    chk("latency_start", last_start_cyc - last_acc_cyc, 1);
    wait_empty();
    chk("acc_after_exact", fflags_acc, 0);

    // inf * 0 -> invalid.
    issue(3, RM_RTZ, INF, 32'h0);
    wait_empty();
    @(negedge clk);
    chk("acc_after_invalid", fflags_acc, 5'b10000);
    @(posedge clk); #1;

    // FIFO full backpressure and in-order drain.
    wb_ready = 0;
    issue(1, RM_RDN, 32'h4040_0001, 32'h4080_0002);
    issue(2, RM_RUP, 32'h40A0_0003, 32'h40C0_0006);
    req_valid = 1; req_tag = 5'd3; req_rm = RM_RMM; req_a = 32'h4100_0005; req_b = 32'h4110_0007;
    base_acc = n_acc; base_ret = n_ret;
    repeat (25) @(negedge clk);
    chk("full_no_accept", n_acc - base_acc, 0);
    chk("full_req_ready", req_ready, 0);
    chk("full_wb_valid", wb_valid, 1);
    @(posedge clk); #1 wb_ready = 1;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (n_acc == base_acc && n < 200);
    chk("third_accepted", n_acc - base_acc, 1);
    chk("drain_before_accept", (n_ret - base_ret) >= 1, 1);
    @(posedge clk); #1 req_valid = 0;
    wait_empty();

    // Multiplier busy holds LAUNCH for 4 cycles.
    base_start = n_start;
    busy_until = cyc + 5;
    issue(12, RM_RMM, 32'h3FC0_0010, 32'h4020_0022);
    wait_empty();
    chk("busy_start_delay", last_start_cyc - last_acc_cyc, 5);
    chk("busy_single_start", n_start - base_start, 1);

    // Clear alone, then clear coinciding with a retire.
    fflags_clr = 1;
    @(posedge clk); #1 fflags_clr = 0;
    @(negedge clk);
    chk("acc_clear_alone", fflags_acc, 0);
    @(posedge clk); #1;
    issue(4, RM_RNE, INF, 32'h0);
    wait_empty();
    wb_ready = 0;
    issue(9, RM_RNE, 32'h4040_0004, TWO);
    wait_wb();
    @(posedge clk); #1 wb_ready = 1; fflags_clr = 1;
    @(posedge clk); #1 fflags_clr = 0;
    @(negedge clk);
    chk("acc_clear_with_retire", fflags_acc, 5'b00001);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure, busy and clears.
    rand_busy = 1; rand_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          issue(5'($urandom_range(0, 31)), rand_rm(), $urandom, $urandom);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          wb_ready = ($urandom_range(0, 3) != 0);
          fflags_clr = ($urandom_range(0, 15) == 0);
        end
      end
    join
    rand_busy = 0; wb_ready = 1; fflags_clr = 0;
    wait_empty();

`ifdef FP_MUL_WATCHDOG_EN
    // Suppressed done: NaN pushed after 15 WAIT cycles; the late done is ignored.
    suppress_done = 1;
    issue(17, RM_RNE, ONE, TWO);
    wait_wb();
    chk("watchdog_latency", cyc - last_acc_cyc, 17);
    chk("watchdog_err", err_timeout, 1);
    repeat (30) @(posedge clk);
    #1 suppress_done = 0;
    wait_empty();
    chk("watchdog_err_sticky", err_timeout, 1);
`else
    chk("err_timeout_tied", err_timeout, 0);
`endif

    // Reset in the middle of WAIT discards everything.
    issue(21, RM_RTZ, 32'h4040_0000, 32'h4040_0000);
    repeat (3) @(posedge clk);
    #1 reset_n = 0;
    @(negedge clk);
    chk("reset_mid_wait", {req_ready, mul_start, mul_rm, mul_a, mul_b, wb_valid, wb_tag,
                           wb_data, wb_fflags, fflags_acc, err_timeout}, 0);
    @(posedge clk); #1 reset_n = 1;
    repeat (12) @(negedge clk);
    chk("no_push_after_reset", wb_valid, 0);
    chk("starts_eq_accepts", n_start, n_acc);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
